// File: rtl/pe_array_seq_ctrl.sv
// rtl/pe_array_seq_ctrl.sv - row sequencer feeding the 16-lane bf16 multiplier array
module pe_array_seq_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW_SIZE   = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [ADDR_WIDTH:0]            num_rows,
    input  logic [ADDR_WIDTH-1:0]          rd_base,
    input  logic [ADDR_WIDTH-1:0]          wr_base,
    output logic                           busy,
    output logic                           done,
    output logic                           rd_en,
    output logic [ADDR_WIDTH-1:0]          rd_addr,
    input  logic [DATA_WIDTH*ROW_SIZE-1:0] a_rd_data,
    input  logic [DATA_WIDTH*ROW_SIZE-1:0] b_rd_data,
    output logic [DATA_WIDTH*ROW_SIZE-1:0] pe_a,
    output logic [DATA_WIDTH*ROW_SIZE-1:0] pe_b,
    input  logic [DATA_WIDTH*ROW_SIZE-1:0] pe_mul,
    output logic                           wr_en,
    output logic [ADDR_WIDTH-1:0]          wr_addr,
    output logic [DATA_WIDTH*ROW_SIZE-1:0] wr_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH:0]   num_rows_q;
    logic [ADDR_WIDTH:0]   issue_cnt;
    logic                  v1;
    logic                  accept;
    logic                  last_issue;

    // issue_cnt counts the row being issued this cycle (1-based), so 2^ADDR_WIDTH fits
    assign accept     = (state == IDLE) && start && !abort;
    assign last_issue = (issue_cnt == num_rows_q);

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = (num_rows == '0) ? DONE : ISSUE;
                ISSUE:   if (last_issue) state_nx = DRAIN;
                // v1 low here means the last product row is being written now
                DRAIN:   if (!v1) state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            v1         <= 1'b0;
            num_rows_q <= '0;
            issue_cnt  <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == DONE);
            rd_en <= (state_nx == ISSUE);
            v1    <= rd_en && !abort;
            wr_en <= v1 && !abort;
            if (v1 && !abort) begin
                wr_data <= pe_mul;
            end
            if (accept) begin
                num_rows_q <= num_rows;
                issue_cnt  <= (ADDR_WIDTH+1)'(1);
                rd_addr    <= rd_base;
                wr_addr    <= wr_base;
            end else begin
                if (state == ISSUE && !last_issue && !abort) begin
                    issue_cnt <= issue_cnt + (ADDR_WIDTH+1)'(1);
                    rd_addr   <= rd_addr + ADDR_WIDTH'(1);
                end
                if (wr_en) begin
                    wr_addr <= wr_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

    // operands are gated to zero outside valid read cycles to keep the array quiet
    assign pe_a = v1 ? a_rd_data : '0;
    assign pe_b = v1 ? b_rd_data : '0;

endmodule

// File: tb/tb_pe_array_seq_ctrl.sv
// tb/tb_pe_array_seq_ctrl.sv - directed-vector bench for pe_array_seq_ctrl
module tb_pe_array_seq_ctrl;

    localparam int RW = 256;
    localparam int MAXC = 270;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [8:0]    num_rows;
    logic [7:0]    rd_base;
    logic [7:0]    wr_base;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [7:0]    rd_addr;
    logic [RW-1:0] a_rd_data;
    logic [RW-1:0] b_rd_data;
    logic [RW-1:0] pe_a;
    logic [RW-1:0] pe_b;
    logic [RW-1:0] pe_mul;
    logic          wr_en;
    logic [7:0]    wr_addr;
    logic [RW-1:0] wr_data;

    logic [RW-1:0] a_mem [256];
    logic [RW-1:0] b_mem [256];
    int            wr_count;

    logic          rec_rd   [MAXC];
    logic [7:0]    rec_ra   [MAXC];
    logic          rec_wr   [MAXC];
    logic [7:0]    rec_wa   [MAXC];
    logic [RW-1:0] rec_wd   [MAXC];
    logic [RW-1:0] rec_pb   [MAXC];
    logic          rec_done [MAXC];
    logic          rec_busy [MAXC];

    int n_checks;
    int n_pass;

    pe_array_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .num_rows  (num_rows),
        .rd_base   (rd_base),
        .wr_base   (wr_base),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .a_rd_data (a_rd_data),
        .b_rd_data (b_rd_data),
        .pe_a      (pe_a),
        .pe_b      (pe_b),
        .pe_mul    (pe_mul),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bf16_mul(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] p;
        logic [9:0]  e;
        logic [6:0]  m;
        if (x[14:7] == 8'd0 || y[14:7] == 8'd0) return {x[15] ^ y[15], 15'd0};
        p = {8'd0, 1'b1, x[6:0]} * {8'd0, 1'b1, y[6:0]};
        e = {2'b0, x[14:7]} + {2'b0, y[14:7]} - 10'd127;
        if (p[15]) begin
            e = e + 10'd1;
            m = p[14:8];
        end else begin
            m = p[13:7];
        end
        return {x[15] ^ y[15], e[7:0], m};
    endfunction

    function automatic logic [RW-1:0] b_row(input int r);
        logic [RW-1:0] row;
        for (int j = 0; j < 16; j++) begin
            row[RW-1-16*j -: 16] = {1'b0, 8'(100 + r / 128), 7'(r ^ j)};
        end
        return row;
    endfunction

    always_comb begin
        pe_mul = '0;
        for (int j = 0; j < 16; j++) begin
            pe_mul[16*j +: 16] = bf16_mul(pe_a[16*j +: 16], pe_b[16*j +: 16]);
        end
    end

    always @(posedge clk) begin
        if (rd_en) begin
            a_rd_data <= a_mem[rd_addr];
            b_rd_data <= b_mem[rd_addr];
        end
        if (wr_en) wr_count <= wr_count + 1;
    end

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run(input int n, input logic [7:0] rb, input logic [7:0] wb,
                       input int len, input int abort_cyc, input int extra_cyc);
        num_rows = 9'(n);
        rd_base  = rb;
        wr_base  = wb;
        start    = 1'b1;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            rec_rd[k]   = rd_en;
            rec_ra[k]   = rd_addr;
            rec_wr[k]   = wr_en;
            rec_wa[k]   = wr_addr;
            rec_wd[k]   = wr_data;
            rec_pb[k]   = pe_b;
            rec_done[k] = done;
            rec_busy[k] = busy;
            start = 1'b0;
            abort = (k == abort_cyc);
            if (k == extra_cyc) begin
                start    = 1'b1;
                num_rows = 9'd1;
                rd_base  = 8'hAA;
                wr_base  = 8'hBB;
            end
        end
    endtask

    task automatic check_run(input string name, input int n, input logic [7:0] rb,
                             input logic [7:0] wb, input int len, input int stop);
        int dc;
        dc = (n == 0) ? 1 : n + 3;
        for (int k = 1; k <= len; k++) begin
            logic          act, e_rd, e_wr, e_pv, e_done, e_busy;
            logic [7:0]    e_ra, e_wa, g_ra, g_wa;
            logic [RW-1:0] e_pb;
            act    = (k <= stop);
            e_rd   = act && k <= n;
            e_wr   = act && k >= 3 && k <= n + 2;
            e_pv   = act && k >= 2 && k <= n + 1;
            e_done = act && k == dc;
            e_busy = act && k <= dc;
            e_ra   = e_rd ? 8'(rb + k - 1) : 8'h00;
            e_wa   = e_wr ? 8'(wb + k - 3) : 8'h00;
            g_ra   = rec_rd[k] ? rec_ra[k] : 8'h00;
            g_wa   = rec_wr[k] ? rec_wa[k] : 8'h00;
            check($sformatf("%s c%0d rd/ra/wr/wa/done/busy", name, k),
                  {rec_rd[k], g_ra, rec_wr[k], g_wa, rec_done[k], rec_busy[k]},
                  {e_rd, e_ra, e_wr, e_wa, e_done, e_busy});
            e_pb = e_pv ? b_mem[8'(rb + k - 2)] : '0;
            check($sformatf("%s c%0d pe_b", name, k), rec_pb[k], e_pb);
            if (e_wr) check($sformatf("%s c%0d wr_data", name, k), rec_wd[k], b_mem[8'(rb + k - 3)]);
        end
    endtask

    initial begin
        int base_cnt;
        clk = 1'b0; rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        num_rows = '0; rd_base = '0; wr_base = '0;
        a_rd_data = '0; b_rd_data = '0; wr_count = 0;
        n_checks = 0; n_pass = 0;
        for (int r = 0; r < 256; r++) begin
            a_mem[r] = {16{16'h3F80}};
            b_mem[r] = b_row(r);
        end
        for (int r = 16; r < 20; r++) b_mem[r] = {16{16'h4000}};

        #1 rst_n = 1'b0;
        #2;
        check("reset ctl", {busy, done, rd_en, wr_en, rd_addr, wr_addr}, '0);
        check("reset wr_data", wr_data, '0);
        check("reset pe", pe_a | pe_b, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(4, 8'h10, 8'h80, 9, 0, 0);
        check_run("basic", 4, 8'h10, 8'h80, 9, 1000);
        check("basic lanes 2.0", rec_wd[5], {16{16'h4000}});

        run(4, 8'hFE, 8'hFF, 9, 0, 0);
        check_run("wrap", 4, 8'hFE, 8'hFF, 9, 1000);

        run(0, 8'h33, 8'h44, 4, 0, 0);
        check_run("zero", 0, 8'h33, 8'h44, 4, 1000);

        run(256, 8'h05, 8'hF0, 261, 0, 0);
        check_run("full", 256, 8'h05, 8'hF0, 261, 1000);

        run(8, 8'h20, 8'h40, 6, 5, 0);
        check_run("abort", 8, 8'h20, 8'h40, 6, 5);
        run(2, 8'h30, 8'h50, 7, 0, 0);
        check_run("restart", 2, 8'h30, 8'h50, 7, 1000);

        run(5, 8'h60, 8'h70, 10, 0, 2);
        check_run("ignored_start", 5, 8'h60, 8'h70, 10, 1000);

        base_cnt = wr_count;
        num_rows = 9'd8; rd_base = 8'h08; wr_base = 8'h90; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun reset ctl", {busy, done, rd_en, wr_en, rd_addr, wr_addr}, '0);
        check("midrun reset wr_data", wr_data, '0);
        check("midrun reset pe", pe_a | pe_b, '0);
        repeat (4) @(negedge clk);
        check("midrun reset writes", 32'(wr_count - base_cnt), 32'd1);
        check("held reset ctl", {busy, done, rd_en, wr_en}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        run(3, 8'h00, 8'h00, 8, 0, 0);
        check_run("recover", 3, 8'h00, 8'h00, 8, 1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
